mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single core memory port between the load/store ALU (port L) and instruction fetch (port F).
//  Picks one requester, latches its command, holds it on the memory bus for MEM_LAT cycles, and returns read data / error to the owner.
//  Sits between alu5/fetch and the memory; neither requester drives mem_* directly.
// PARAMETERS
//  MEM_LAT        2  cycles mem_req+command held stable; mem_rdata/mem_err sampled on the last one (>=1)
//  MAX_L_STREAK   4  consecutive L grants allowed while F is pending before F is forced (>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  l_req        in   1        L request; command valid while high
//  l_addr       in   XLEN     L word-aligned address
//  l_byteen     in   XLEN/8   L byte enables
//  l_we         in   1        L write enable
//  l_wdata      in   XLEN     L write data (lane-aligned)
//  l_gnt        out  1        L command accepted this cycle
//  l_rvalid     out  1        L response pulse
//  l_rdata      out  XLEN     L read data (0 for writes)
//  l_err        out  1        L bus error, valid with l_rvalid
//  f_req        in   1        F request (always a word read)
//  f_addr       in   XLEN     F word-aligned address
//  f_flush      in   1        discard any outstanding/accepted F response
//  f_gnt        out  1        F command accepted this cycle
//  f_rvalid     out  1        F response pulse
//  f_rdata      out  XLEN     F read data
//  f_err        out  1        F bus error, valid with f_rvalid
//  mem_addr     out  XLEN     memory address
//  mem_byteen   out  XLEN/8   memory byte enables
//  mem_we       out  1        memory write enable
//  mem_req      out  1        memory request
//  mem_wdata    out  XLEN     memory write data
//  mem_rdata    in   XLEN     memory read data
//  mem_err      in   1        memory error
// BEHAVIOUR
//  Reset: state IDLE, streak=0, owner=L; all outputs 0. An async reset mid-transaction drops mem_req immediately and no rvalid is produced.
//  FSM: IDLE -> BUS (MEM_LAT cycles, down-counter) -> RESP (1 cycle) -> IDLE, or -> BUS if a new grant is issued in RESP.
//  Arbitration happens in IDLE and RESP only. *_gnt is combinational from *_req and state; at most one is high.
//  Command regs (addr, byteen, we, wdata, owner) load on the gnt edge. F loads byteen=all-ones, we=0, wdata=0.
//  Requester may drop req or change its command after gnt. A req held high after gnt is a new request.
//  Priority: L wins, except F wins when f_req && streak==MAX_L_STREAK.
//  streak: +1 on an L grant while f_req is high (saturating at MAX_L_STREAK). 0 on an F grant or any cycle with f_req low.
//  BUS: mem_req=1 with the latched command; other mem_* outputs are 0 outside BUS.
//    On the last BUS cycle, capture mem_rdata (only if we=0, else 0) and mem_err into response regs.
//  RESP: the owner's rvalid=1, with rdata/err from the response regs. The non-owner's rdata/err=0.
//  Latency: gnt in cycle 0, mem_req in cycles 1..MEM_LAT, rvalid in cycle MEM_LAT+1. Back-to-back throughput is one per MEM_LAT+1 cycles.
//  f_flush: sets a drop flag when F owns BUS/RESP, or when f_gnt is high in the same cycle.
//    The bus access completes normally. f_rvalid is suppressed for that transaction. The flag clears on leaving RESP.
//    f_flush never affects L. With f_flush and f_req both high in IDLE, the grant proceeds but the response is dropped.
//  Simultaneous l_req & f_req with streak<MAX: L granted, F waits, f_gnt=0.
//  mem_err is reported, not retried; the arbiter keeps running.
// STRUCTURE
//  core_config_pkg: XLEN (existing); add mem_arb_state_t {IDLE,BUS,RESP} and mem_owner_t {OWN_L,OWN_F}.
//  One combinational sub-module, mem_arb_pick: (l_req, f_req, streak_full) -> {l_gnt, f_gnt}.
//  FSM, counters and datapath regs live in mem_port_arbiter.
// TESTING
//  L-only LW 0x100, mem_rdata=0xDEADBEEF: l_gnt@0, mem_req@1-2 byteen 4'hF, l_rvalid@3 with 0xDEADBEEF, f_* stay 0.
//  l_req & f_req both high continuously: grants L,L,L,L,F,L...; f_gnt exactly every 5th grant; mem_req never gaps between RESP and BUS.
//  SB 0x0000AA00, byteen 4'b0010, we=1: mem_wdata=0x0000AA00 held 2 cycles; l_rvalid with l_rdata=0.
//  F read granted, f_flush pulsed in the 1st BUS cycle: mem_req still 2 cycles, f_rvalid never asserts; next F read returns data.
//  mem_err=1 on the last BUS cycle of an L read: l_err=1 with l_rvalid; the following transaction has l_err=0.
//  rst_n low during the 2nd BUS cycle: all outputs 0 at once; after release, the first f_req is granted in IDLE.

Source files
------------

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the memory-port arbiter and its neighbours.
// Holds the datapath width and the arbiter's state and owner encodings.
package core_config_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } mem_arb_state_t;

  typedef enum logic {
    OWN_L,
    OWN_F
  } mem_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the load/store port (L) and fetch (F).
// L has priority unless F has been starved for a full streak of L grants.
module mem_arb_pick (
  input  logic l_req,
  input  logic f_req,
  input  logic streak_full,
  output logic l_gnt,
  output logic f_gnt
);

  always_comb begin
    f_gnt = f_req && (!l_req || streak_full);
    l_gnt = l_req && !f_gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single core memory port between the load/store ALU (L) and instruction fetch (F).
// One command at a time is latched, held on the bus for MEM_LAT cycles, and its response returned to the owner.
module mem_port_arbiter
  import core_config_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int MAX_L_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l_req,
  input  logic [XLEN-1:0]   l_addr,
  input  logic [XLEN/8-1:0] l_byteen,
  input  logic              l_we,
  input  logic [XLEN-1:0]   l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [XLEN-1:0]   l_rdata,
  output logic              l_err,
  input  logic              f_req,
  input  logic [XLEN-1:0]   f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [XLEN-1:0]   f_rdata,
  output logic              f_err,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_byteen,
  output logic              mem_we,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err
);

  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STREAK_W = $clog2(MAX_L_STREAK + 1);

  mem_arb_state_t      state;
  mem_owner_t          owner;
  logic [CNT_W-1:0]    cnt;
  logic [STREAK_W-1:0] streak;
  logic [XLEN-1:0]     cmd_addr;
  logic [XLEN/8-1:0]   cmd_byteen;
  logic                cmd_we;
  logic [XLEN-1:0]     cmd_wdata;
  logic [XLEN-1:0]     rsp_rdata;
  logic                rsp_err;
  logic                drop;

  logic arb_en;
  logic streak_full;
  logic in_bus;
  logic in_resp;

  assign arb_en      = (state == IDLE) || (state == RESP);
  assign streak_full = (streak == STREAK_W'(MAX_L_STREAK));
  assign in_bus      = (state == BUS);
  assign in_resp     = (state == RESP);

  mem_arb_pick u_pick (
    .l_req       (l_req && arb_en),
    .f_req       (f_req && arb_en),
    .streak_full (streak_full),
    .l_gnt       (l_gnt),
    .f_gnt       (f_gnt)
  );

  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_L;
      cnt        <= '0;
      streak     <= '0;
      cmd_addr   <= '0;
      cmd_byteen <= '0;
      cmd_we     <= 1'b0;
      cmd_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      drop       <= 1'b0;
    end else begin
      // The streak only measures how long F has been kept waiting behind L.
      if (!f_req || f_gnt) begin
        streak <= '0;
      end else if (l_gnt && !streak_full) begin
        streak <= streak + STREAK_W'(1);
      end

      if (l_gnt) begin
        owner      <= OWN_L;
        cmd_addr   <= l_addr;
        cmd_byteen <= l_byteen;
        cmd_we     <= l_we;
        cmd_wdata  <= l_wdata;
      end else if (f_gnt) begin
        owner      <= OWN_F;
        cmd_addr   <= f_addr;
        cmd_byteen <= '1;
        cmd_we     <= 1'b0;
        cmd_wdata  <= '0;
      end

      case (state)
        IDLE, RESP: begin
          // Leaving RESP always clears the drop flag unless the new F grant is itself flushed.
          drop <= f_flush && f_gnt;
          if (l_gnt || f_gnt) begin
            state <= BUS;
            cnt   <= CNT_W'(MEM_LAT - 1);
          end else begin
            state <= IDLE;
          end
        end
        BUS: begin
          if (owner == OWN_F && f_flush) drop <= 1'b1;
          if (cnt == '0) begin
            state     <= RESP;
            rsp_rdata <= cmd_we ? '0 : mem_rdata;
            rsp_err   <= mem_err;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush arriving during RESP must still kill that same cycle's F response.
  always_comb begin
    mem_req    = in_bus;
    mem_addr   = in_bus ? cmd_addr   : '0;
    mem_byteen = in_bus ? cmd_byteen : '0;
    mem_we     = in_bus && cmd_we;
    mem_wdata  = in_bus ? cmd_wdata  : '0;

    l_rvalid = in_resp && (owner == OWN_L);
    l_rdata  = l_rvalid ? rsp_rdata : '0;
    l_err    = l_rvalid && rsp_err;

    f_rvalid = in_resp && (owner == OWN_F) && !drop && !f_flush;
    f_rdata  = f_rvalid ? rsp_rdata : '0;
    f_err    = f_rvalid && rsp_err;
  end

endmodule
